// File: rtl/ws2812_bit_encoder_if.sv
// Handshake bundle between the WS2812 bit encoder, the frame controller and
// the upstream shift register, plus the encoded data line.
interface ws2812_bit_encoder_if;
    logic start;
    logic bit_in;
    logic shift_en;
    logic word_req;
    logic dout;
    logic busy;
    logic frame_done;

    modport master (
        output start,
        output bit_in,
        input  shift_en,
        input  word_req,
        input  dout,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  start,
        input  bit_in,
        output shift_en,
        output word_req,
        output dout,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/ws2812_bit_encoder.sv
// WS2812 NRZ line encoder: turns the upstream serial bit stream into timed
// high/low pulses, paces the shift register and closes each frame with a latch gap.
module ws2812_bit_encoder #(
    parameter int unsigned BITS_PER_LED = 24,
    parameter int unsigned N_LEDS       = 64,
    parameter int unsigned T0H          = 20,
    parameter int unsigned T1H          = 40,
    parameter int unsigned T_BIT        = 63,
    parameter int unsigned T_RES        = 3000
) (
    input  logic                  clk,
    input  logic                  rst,
    ws2812_bit_encoder_if.slave   bus
);

    localparam int unsigned CYC_W = (T_BIT > 1)        ? $clog2(T_BIT)        : 1;
    localparam int unsigned BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;
    localparam int unsigned LED_W = (N_LEDS > 1)       ? $clog2(N_LEDS)       : 1;
    localparam int unsigned LAT_W = (T_RES > 1)        ? $clog2(T_RES)        : 1;

    localparam logic [CYC_W-1:0] CYC_ZERO = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
    localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H);
    localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H);
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_LED - 1);
    localparam logic [LED_W-1:0] LED_ZERO = {LED_W{1'b0}};
    localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);
    localparam logic [LED_W-1:0] LED_LAST = LED_W'(N_LEDS - 1);
    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(T_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BIT   = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t             state_r,      state_s;
    logic [CYC_W-1:0]   cyc_r,        cyc_s;
    logic [BIT_W-1:0]   bit_cnt_r,    bit_cnt_s;
    logic [LED_W-1:0]   led_cnt_r,    led_cnt_s;
    logic [LAT_W-1:0]   lat_cnt_r,    lat_cnt_s;
    logic               bit_q_r,      bit_q_s;
    logic               dout_r,       dout_s;
    logic               shift_en_r,   shift_en_s;
    logic               word_req_r,   word_req_s;
    logic               busy_r,       busy_s;
    logic               frame_done_r, frame_done_s;

    function automatic logic [CYC_W-1:0] high_time(input logic b);
        return b ? T1H_C : T0H_C;
    endfunction

    // State and output registers; reset clears everything so no pulse escapes the reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cyc_r        <= CYC_ZERO;
            bit_cnt_r    <= BIT_ZERO;
            led_cnt_r    <= LED_ZERO;
            lat_cnt_r    <= LAT_ZERO;
            bit_q_r      <= 1'b0;
            dout_r       <= 1'b0;
            shift_en_r   <= 1'b0;
            word_req_r   <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cyc_r        <= cyc_s;
            bit_cnt_r    <= bit_cnt_s;
            led_cnt_r    <= led_cnt_s;
            lat_cnt_r    <= lat_cnt_s;
            bit_q_r      <= bit_q_s;
            dout_r       <= dout_s;
            shift_en_r   <= shift_en_s;
            word_req_r   <= word_req_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

    // Next-state and next-output logic; every register value is computed one cycle ahead.
    always_comb begin
        state_s      = state_r;
        cyc_s        = cyc_r;
        bit_cnt_s    = bit_cnt_r;
        led_cnt_s    = led_cnt_r;
        lat_cnt_s    = lat_cnt_r;
        bit_q_s      = bit_q_r;
        dout_s       = 1'b0;
        shift_en_s   = 1'b0;
        word_req_s   = 1'b0;
        busy_s       = busy_r;
        frame_done_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s   = ST_BIT;
                    cyc_s     = CYC_ZERO;
                    bit_cnt_s = BIT_ZERO;
                    led_cnt_s = LED_ZERO;
                    busy_s    = 1'b1;
                    dout_s    = 1'b1;
                end else begin
                    busy_s    = 1'b0;
                end
            end

            ST_BIT: begin
                busy_s = 1'b1;
                if (cyc_r == CYC_LAST) begin
                    cyc_s = CYC_ZERO;
                    if ((bit_cnt_r == BIT_LAST) && (led_cnt_r == LED_LAST)) begin
                        state_s   = ST_LATCH;
                        lat_cnt_s = LAT_ZERO;
                        dout_s    = 1'b0;
                    end else if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_s = BIT_ZERO;
                        led_cnt_s = led_cnt_r + LED_ONE;
                        dout_s    = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                        dout_s    = 1'b1;
                    end
                end else begin
                    cyc_s = cyc_r + CYC_ONE;
                    // The upstream stage updates bit_in on the edge that opens the
                    // period, so the settled value is captured one edge later; the
                    // first cycle of a period is high for either bit value anyway.
                    if (cyc_r == CYC_ZERO) begin
                        bit_q_s = bus.bit_in;
                        dout_s  = (cyc_s < high_time(bus.bit_in));
                    end else begin
                        dout_s  = (cyc_s < high_time(bit_q_r));
                    end
                    if (cyc_s == CYC_LAST) begin
                        if (bit_cnt_r != BIT_LAST) begin
                            shift_en_s = 1'b1;
                        end else if (led_cnt_r != LED_LAST) begin
                            word_req_s = 1'b1;
                        end else begin
                            shift_en_s = 1'b0;
                        end
                    end else begin
                        shift_en_s = 1'b0;
                    end
                end
            end

            ST_LATCH: begin
                if (lat_cnt_r == LAT_LAST) begin
                    state_s      = ST_IDLE;
                    lat_cnt_s    = LAT_ZERO;
                    busy_s       = 1'b0;
                    frame_done_s = 1'b1;
                end else begin
                    lat_cnt_s    = lat_cnt_r + LAT_ONE;
                    busy_s       = 1'b1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign bus.dout       = dout_r;
    assign bus.shift_en   = shift_en_r;
    assign bus.word_req   = word_req_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Bench for ws2812_bit_encoder: reset/abort vector table, randomized frames
// against a waveform model, and a decoded chain with full-size bit timing.
module tb_ws2812_bit_encoder;

    localparam int B     = 4;
    localparam int N     = 2;
    localparam int T0H   = 2;
    localparam int T1H   = 4;
    localparam int TB    = 6;
    localparam int TR    = 10;
    localparam int NB    = B * N;
    localparam int TOTAL = NB * TB + TR;

    localparam int  N2     = 3;
    localparam int  BUDGET = 24 * N2 * 63 + 3000 + 20;
    localparam logic [23:0] GRB = 24'hE15F10;

    typedef logic [B-1:0] word_t;
    typedef struct packed {
        logic       rst;
        logic       start;
        logic       bit_in;
        logic [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    word_t cur_words [N];
    word_t nxt_words [N];
    word_t up_words  [N];
    int    up_led;
    int    up_bit;
    vec_t  tbl [18];

    always #5 clk = ~clk;

    ws2812_bit_encoder_if bus ();
    ws2812_bit_encoder_if bus2 ();

    ws2812_bit_encoder #(
        .BITS_PER_LED(B), .N_LEDS(N), .T0H(T0H), .T1H(T1H), .T_BIT(TB), .T_RES(TR)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    ws2812_bit_encoder #(
        .BITS_PER_LED(24), .N_LEDS(N2), .T0H(20), .T1H(40), .T_BIT(63), .T_RES(3000)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.dout, bus.shift_en, bus.word_req, bus.busy, bus.frame_done};
    endfunction

    function automatic logic up_val();
        if (up_led >= 0 && up_led < N && up_bit >= 0 && up_bit < B)
            return up_words[up_led][up_bit];
        else
            return 1'b0;
    endfunction

    // One frame: upstream reacts to shift_en/word_req; every cycle is compared with
    // the waveform the bit sequence calls for.
    task automatic run_frame(input bit noise, input bit started, input bit chain);
        word_t      mw [N];
        int         n_se, n_wr, n_busy, i, p, h, n;
        logic [4:0] got, exp;
        logic       b;
        mw     = cur_words;
        n_se   = 0;
        n_wr   = 0;
        n_busy = 0;
        if (!started) begin
            up_words   = cur_words;
            up_led     = 0;
            up_bit     = B - 1;
            bus.bit_in = up_val();
            bus.start  = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        for (int t = 0; t <= TOTAL; t++) begin
            @(negedge clk);
            got = outs();
            if (t < NB * TB) begin
                i   = t / TB;
                p   = t % TB;
                b   = mw[i / B][B - 1 - (i % B)];
                h   = b ? T1H : T0H;
                exp = {p < h,
                       (p == TB - 1) && (i % B != B - 1),
                       (p == TB - 1) && (i % B == B - 1) && (i / B < N - 1),
                       1'b1, 1'b0};
            end else if (t < TOTAL) begin
                exp = 5'b00010;
            end else begin
                exp = 5'b00001;
            end
            check($sformatf("wave_t%0d", t), {27'd0, got}, {27'd0, exp});
            if (got[3]) n_se++;
            if (got[2]) n_wr++;
            if (got[1]) n_busy++;
            @(posedge clk);
            #1;
            n = t + 1;
            if (got[3]) up_bit--;
            if (got[2]) begin
                up_led++;
                up_bit = B - 1;
            end
            if (n < NB * TB) begin
                p = n % TB;
                if (noise && p != 0 && p != TB - 1) bus.bit_in = 1'($urandom_range(0, 1));
                else bus.bit_in = up_val();
                bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (n < TOTAL) begin
                bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (n == TOTAL) begin
                bus.start = chain;
                if (chain) begin
                    up_words   = nxt_words;
                    up_led     = 0;
                    up_bit     = B - 1;
                    bus.bit_in = up_val();
                end
            end else if (!chain) begin
                bus.start = 1'b0;
            end
        end
        check("shift_en_count", n_se,   N * (B - 1));
        check("word_req_count", n_wr,   N - 1);
        check("busy_cycles",    n_busy, NB * TB + TR);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] sr, word;
        int          hi, nbits, nwords;
        logic        d, se, wr, done, prev, hb;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 5'b00000};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 5'b00000};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 5'b00000};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 5'b00000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 5'b00000};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 5'b10010};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'b10010};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'b10010};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 5'b10010};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 5'b00010};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'b01010};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 5'b10010};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 5'b10010};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 5'b00000};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 5'b00000};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 5'b00000};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 5'b00000};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 5'b00000};

        bus.start   = 1'b0;
        bus.bit_in  = 1'b0;
        bus2.start  = 1'b0;
        bus2.bit_in = 1'b0;

        // Reset with start held, one bit period, then an abort while dout is high.
        for (int k = 0; k < 18; k++) begin
            rst        = tbl[k].rst;
            bus.start  = tbl[k].start;
            bus.bit_in = tbl[k].bit_in;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", k), {27'd0, outs()}, {27'd0, tbl[k].exp});
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < N; k++) cur_words[k] = '1;
        run_frame(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) cur_words[k] = '0;
        run_frame(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N; k++) cur_words[k] = word_t'($urandom_range(0, 15));
            run_frame(1'b1, 1'b0, 1'b0);
        end
        for (int k = 0; k < N; k++) begin
            cur_words[k] = word_t'($urandom_range(0, 15));
            nxt_words[k] = word_t'($urandom_range(0, 15));
        end
        run_frame(1'b1, 1'b0, 1'b1);
        cur_words = nxt_words;
        run_frame(1'b1, 1'b1, 1'b0);

        // Full-size timing chained with a shift register reloaded on word_req.
        sr          = GRB;
        bus2.bit_in = sr[23];
        bus2.start  = 1'b1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        hi     = 0;
        nbits  = 0;
        nwords = 0;
        word   = 24'd0;
        prev   = 1'b0;
        done   = 1'b0;
        for (int c = 0; c < BUDGET && !done; c++) begin
            @(negedge clk);
            d    = bus2.dout;
            se   = bus2.shift_en;
            wr   = bus2.word_req;
            done = bus2.frame_done;
            if (d) begin
                hi++;
            end else if (prev) begin
                hb   = (hi >= 30);
                word = {word[22:0], hb};
                hi   = 0;
                nbits++;
                if (nbits == 24) begin
                    check($sformatf("led_word%0d", nwords), {8'd0, word}, {8'd0, GRB});
                    nwords++;
                    nbits = 0;
                end
            end
            prev = d;
            @(posedge clk);
            #1;
            if (wr) sr = GRB;
            else if (se) sr = {sr[22:0], 1'b0};
            bus2.bit_in = sr[23];
        end
        check("chain_frame_done", {31'd0, done}, 32'd1);
        check("chain_words", nwords, N2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
